// File: rtl/sad_min_select_if.sv
// Handshake bundle between the SAD pipeline, the minimum selector and the
// motion-vector writer.
interface sad_min_select_if #(
   parameter int SAD_W  = 12,
   parameter int ADDR_W = 8
);
   logic                    start;
   logic                    in_valid;
   logic [SAD_W+ADDR_W-1:0] in_res;
   logic                    busy;
   logic                    done;
   logic [SAD_W-1:0]        best_sad;
   logic [ADDR_W-1:0]       best_addr;
   logic [3:0]              mv_row;
   logic [3:0]              mv_col;

   modport master (
      output start, in_valid, in_res,
      input  busy, done, best_sad, best_addr, mv_row, mv_col
   );

   modport slave (
      input  start, in_valid, in_res,
      output busy, done, best_sad, best_addr, mv_row, mv_col
   );
endinterface

// File: rtl/sad_min_select.sv
// Tracks the minimum SAD over a window of NUM_CAND candidates and registers
// the winning SAD/address (the motion vector) with a one-cycle done pulse.
module sad_min_select #(
   parameter int SAD_W    = 12,
   parameter int ADDR_W   = 8,
   parameter int NUM_CAND = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   sad_min_select_if.slave  bus
);
   localparam int CNT_W = $clog2(NUM_CAND) + 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_CAND - 1);

   typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

   typedef struct packed {
      logic [SAD_W-1:0]  sad;
      logic [ADDR_W-1:0] addr;
   } cand_t;

   localparam cand_t CAND_INIT = '{sad: '1, addr: '0};

   state_t            state, state_n;
   logic [CNT_W-1:0]  cnt, cnt_n;
   cand_t             run, run_n;
   cand_t             best, best_n;
   cand_t             in_cand, cmp;
   logic              take;
   logic              busy_q, done_q;

   assign in_cand = bus.in_res;

   // First beat of a window always loads; later beats only on a strict win,
   // so ties keep the earlier candidate.
   always_comb begin
      take = (cnt == '0) || (in_cand.sad < run.sad);
      cmp  = take ? in_cand : run;
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      run_n   = run;
      best_n  = best;
      case (state)
         IDLE: begin
            if (bus.start) begin
               state_n = SEARCH;
               cnt_n   = '0;
               run_n   = CAND_INIT;
            end
         end
         SEARCH: begin
            if (bus.start) begin
               state_n = SEARCH;
               cnt_n   = '0;
               run_n   = CAND_INIT;
            end else if (bus.in_valid) begin
               run_n = cmp;
               cnt_n = cnt + 1'b1;
               if (cnt == LAST) begin
                  state_n = DONE;
                  best_n  = cmp;
               end
            end
         end
         DONE: begin
            if (bus.start) begin
               state_n = SEARCH;
               cnt_n   = '0;
               run_n   = CAND_INIT;
            end else begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         run    <= CAND_INIT;
         best   <= CAND_INIT;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         run    <= run_n;
         best   <= best_n;
         busy_q <= (state_n == SEARCH);
         done_q <= (state_n == DONE);
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.best_sad  = best.sad;
   assign bus.best_addr = best.addr;
   assign bus.mv_row    = best.addr[7:4];
   assign bus.mv_col    = best.addr[3:0];
endmodule

// File: tb/tb_sad_min_select.sv
// Directed + randomized check of sad_min_select against a window-level
// minimum model (NUM_CAND=4 main instance, NUM_CAND=1 corner instance).
module tb_sad_min_select;
   localparam int N = 4;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;
   int   exp_sad;
   int   exp_addr;
   int   w_sad[$];
   int   w_addr[$];

   sad_min_select_if #(.SAD_W(12), .ADDR_W(8)) b4 ();
   sad_min_select_if #(.SAD_W(12), .ADDR_W(8)) b1 ();

   sad_min_select #(.SAD_W(12), .ADDR_W(8), .NUM_CAND(N)) dut (
      .clk(clk), .rst_n(rst_n), .bus(b4)
   );
   sad_min_select #(.SAD_W(12), .ADDR_W(8), .NUM_CAND(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(b1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One clock: drive at negedge, let the posedge happen, sample at next negedge.
   task automatic cyc(input logic s, input logic v, input int sd, input int ad);
      b4.start    = s;
      b4.in_valid = v;
      b4.in_res   = {sd[11:0], ad[7:0]};
      @(posedge clk);
      @(negedge clk);
      b4.start    = 1'b0;
      b4.in_valid = 1'b0;
   endtask

   // Reference: winner is the earliest index holding the smallest SAD.
   function automatic int ref_idx();
      int k = 0;
      for (int i = 1; i < w_sad.size(); i++)
         if (w_sad[i] < w_sad[k]) k = i;
      return k;
   endfunction

   task automatic chk_hold(input string tag);
      chk({tag, "_sad"},  32'(b4.best_sad),  32'(exp_sad));
      chk({tag, "_addr"}, 32'(b4.best_addr), 32'(exp_addr));
   endtask

   // Start (with a SAD-0 candidate that must be dropped), then feed w_* with gaps.
   task automatic run_window(input int gap_max, input bit idle_after);
      int k;
      cyc(1'b1, 1'b1, 0, 8'hA5);
      chk("start_busy", 32'(b4.busy), 32'd1);
      chk("start_done", 32'(b4.done), 32'd0);
      for (int i = 0; i < N; i++) begin
         int g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
         for (int j = 0; j < g; j++) begin
            cyc(1'b0, 1'b0, int'($urandom_range(0, 4095)), int'($urandom_range(0, 255)));
            chk("gap_busy", 32'(b4.busy), 32'd1);
            chk("gap_done", 32'(b4.done), 32'd0);
         end
         cyc(1'b0, 1'b1, w_sad[i], w_addr[i]);
         if (i < N - 1) begin
            chk("mid_done", 32'(b4.done), 32'd0);
            chk("mid_busy", 32'(b4.busy), 32'd1);
            chk_hold("mid_hold");
         end
      end
      k = ref_idx();
      exp_sad  = w_sad[k];
      exp_addr = w_addr[k];
      chk("end_done", 32'(b4.done), 32'd1);
      chk("end_busy", 32'(b4.busy), 32'd0);
      chk_hold("end_best");
      chk("end_row", 32'(b4.mv_row), 32'(exp_addr / 16));
      chk("end_col", 32'(b4.mv_col), 32'(exp_addr % 16));
      if (idle_after) begin
         cyc(1'b0, 1'b1, 0, 8'h00);
         chk("post_done", 32'(b4.done), 32'd0);
         chk("post_busy", 32'(b4.busy), 32'd0);
         chk_hold("post_hold");
      end
   endtask

   task automatic set_win(input int s0, s1, s2, s3, input int a0);
      w_sad  = '{s0, s1, s2, s3};
      w_addr = '{a0, a0 + 1, a0 + 2, a0 + 3};
   endtask

   initial begin
      checks = 0; failures = 0;
      b4.start = 1'b0; b4.in_valid = 1'b0; b4.in_res = '0;
      b1.start = 1'b0; b1.in_valid = 1'b0; b1.in_res = '0;
      rst_n = 1'b0;
      cyc(1'b0, 1'b0, 0, 0);
      cyc(1'b0, 1'b0, 0, 0);
      rst_n = 1'b1;
      exp_sad = 4095; exp_addr = 0;
      chk("rst_sad",  32'(b4.best_sad),  32'd4095);
      chk("rst_addr", 32'(b4.best_addr), 32'd0);
      chk("rst_row",  32'(b4.mv_row),    32'd0);
      chk("rst_col",  32'(b4.mv_col),    32'd0);
      chk("rst_busy", 32'(b4.busy),      32'd0);
      chk("rst_done", 32'(b4.done),      32'd0);

      // Valid beats in IDLE are ignored.
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 1'b1, 5, 8'h11);
         chk("idle_busy", 32'(b4.busy), 32'd0);
         chk("idle_done", 32'(b4.done), 32'd0);
         chk_hold("idle_hold");
      end

      w_sad = '{300, 120, 450, 200}; w_addr = '{8'h3B, 8'h3C, 8'h3D, 8'h3E};
      run_window(0, 1'b1);
      chk("basic_sad", 32'(b4.best_sad),  32'd120);
      chk("basic_row", 32'(b4.mv_row),    32'd3);
      chk("basic_col", 32'(b4.mv_col),    32'd12);

      set_win(50, 50, 80, 10, 8'h20);   run_window(0, 1'b1);
      set_win(50, 50, 80, 90, 8'h40);   run_window(0, 1'b1);
      set_win(4095, 4095, 4095, 4095, 8'h77); run_window(0, 1'b1);

      // Gap pattern 1,0,0,1,...
      set_win(900, 700, 800, 650, 8'h90);
      cyc(1'b1, 1'b0, 0, 0);
      for (int i = 0; i < N; i++) begin
         cyc(1'b0, 1'b1, w_sad[i], w_addr[i]);
         if (i < N - 1) begin
            chk("gap_mid_done", 32'(b4.done), 32'd0);
            cyc(1'b0, 1'b0, 1, 8'hFF);
            cyc(1'b0, 1'b0, 2, 8'hFE);
            chk("gap_stall_busy", 32'(b4.busy), 32'd1);
         end
      end
      exp_sad = 650; exp_addr = 8'h93;
      chk("gap_done", 32'(b4.done), 32'd1);
      chk_hold("gap_best");
      cyc(1'b0, 1'b0, 0, 0);

      // Restart after two candidates; the old minimum of 5 must not survive.
      cyc(1'b1, 1'b0, 0, 0);
      cyc(1'b0, 1'b1, 5, 8'h01);
      cyc(1'b0, 1'b1, 9, 8'h02);
      chk("pre_restart_done", 32'(b4.done), 32'd0);
      set_win(100, 70, 80, 90, 8'hC0);
      run_window(0, 1'b0);
      chk("restart_sad", 32'(b4.best_sad), 32'd70);

      // Start issued in the DONE cycle is honoured.
      set_win(30, 20, 25, 40, 8'hD0);
      run_window(1, 1'b1);

      // Reset mid-window: no done, best restored.
      cyc(1'b1, 1'b0, 0, 0);
      cyc(1'b0, 1'b1, 3, 8'h44);
      cyc(1'b0, 1'b1, 2, 8'h45);
      rst_n = 1'b0;
      cyc(1'b0, 1'b1, 1, 8'h46);
      rst_n = 1'b1;
      exp_sad = 4095; exp_addr = 0;
      chk("mrst_busy", 32'(b4.busy), 32'd0);
      chk("mrst_done", 32'(b4.done), 32'd0);
      chk_hold("mrst_best");
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, 1'b1, 0, 8'h33);
         chk("mrst_idle_done", 32'(b4.done), 32'd0);
      end
      chk_hold("mrst_hold");

      // Random windows: narrow SAD range stresses ties.
      for (int r = 0; r < 30; r++) begin
         w_sad.delete(); w_addr.delete();
         for (int i = 0; i < N; i++) begin
            w_sad.push_back((r % 2 == 0) ? int'($urandom_range(0, 4095)) : int'($urandom_range(0, 3)));
            w_addr.push_back(int'($urandom_range(0, 255)));
         end
         run_window(int'($urandom_range(0, 2)), bit'($urandom_range(0, 1)));
      end
      cyc(1'b0, 1'b0, 0, 0);

      // NUM_CAND=1: first valid candidate closes the window.
      for (int r = 0; r < 3; r++) begin
         logic [11:0] sd;
         logic [7:0]  ad;
         sd = 12'($urandom_range(0, 4095));
         ad = 8'($urandom_range(0, 255));
         b1.start = 1'b1;
         @(posedge clk); @(negedge clk);
         b1.start = 1'b0;
         chk("n1_busy", 32'(b1.busy), 32'd1);
         b1.in_valid = 1'b1; b1.in_res = {sd, ad};
         @(posedge clk); @(negedge clk);
         b1.in_valid = 1'b0;
         chk("n1_done", 32'(b1.done), 32'd1);
         chk("n1_sad",  32'(b1.best_sad),  32'(sd));
         chk("n1_addr", 32'(b1.best_addr), 32'(ad));
         @(posedge clk); @(negedge clk);
         chk("n1_idle", 32'(b1.done), 32'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
